adder_result_checker: RTL and testbench

- Response-side companion for the 32-bit Manchester carry chain adder.
- A stimulus source drives A, B and Cin into the adder; this block consumes the same operands plus the adder's Sum/Cout.
- It computes the golden A+B+Cin, aligns it to the adder latency, and compares.
- It counts passes and failures and captures the first failing vector; it is synthesizable so it can sit on-chip or in a bench.

---
 rtl/adder_result_checker.sv | 232 +++++++++++++++++++++++
 tb/tb_adder_result_checker.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : adder_result_checker
// Purpose  : Response checker for a WIDTH-bit adder. Consumes the operands
//            driven into the adder together with the adder's Sum/Cout,
//            recomputes A+B+Cin, aligns it to the adder latency and counts
//            matching / mismatching vectors. The first failing vector of a
//            run is captured.
// Revision : 1.0 - initial release
//
// Parameters:
//   WIDTH - operand / sum width
//   LAT   - adder latency in cycles (0..7, 0 = combinational adder)
//   CNT_W - width of the pass / fail counters (saturating)
//
// Ports:
//   clk, rst           - clock (rising edge), synchronous active-high reset
//   start, stop        - one-cycle run control pulses
//   in_valid, in_a,
//   in_b, in_cin       - operand vector presented to the adder
//   dut_sum, dut_cout  - adder response
//   busy, done         - run status (RUN/DRAIN, DONE)
//   err                - sticky mismatch flag for the current run
//   pass_cnt, fail_cnt - saturating result counters
//   ff_a .. ff_cout    - first failing vector and its observed response
//
// Optional build macro:
//   CHK_STOP_ON_FAIL_EN - first mismatch ends sampling as if stop was pulsed
// ============================================================================
module adder_result_checker #(
  parameter int WIDTH = 32,
  parameter int LAT   = 0,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic             ff_cin,
  output logic [WIDTH-1:0] ff_sum,
  output logic             ff_cout
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  // DRAIN lasts LAT+1 cycles: the counter is loaded with LAT and the FSM
  // leaves DRAIN in the cycle it reads zero.
  localparam logic [2:0] c_DRAIN_INIT = 3'(LAT);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [1:0]       r_state;
  logic [2:0]       r_drain_cnt;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic             r_err;
  logic [WIDTH-1:0] r_ff_a;
  logic [WIDTH-1:0] r_ff_b;
  logic             r_ff_cin;
  logic [WIDTH-1:0] r_ff_sum;
  logic             r_ff_cout;

  logic             w_accept;
  logic             w_start_run;
  logic             w_stop_run;
  logic             w_fail_stop;
  logic             w_cmp_valid;
  logic [WIDTH-1:0] w_cmp_a;
  logic [WIDTH-1:0] w_cmp_b;
  logic             w_cmp_cin;
  logic [WIDTH:0]   w_expected;
  logic             w_match;

  assign w_accept    = (r_state == c_RUN) && in_valid;
  // start is only honoured from IDLE or DONE, which also makes stop win
  // over start in a RUN cycle.
  assign w_start_run = start && ((r_state == c_IDLE) || (r_state == c_DONE));

  // --------------------------------------------------------------------------
  // Operand delay line aligning the golden result with the adder latency
  // --------------------------------------------------------------------------
  generate
    if (LAT == 0) begin : g_lat0
      assign w_cmp_valid = w_accept;
      assign w_cmp_a     = in_a;
      assign w_cmp_b     = in_b;
      assign w_cmp_cin   = in_cin;
    end else begin : g_pipe
      logic             r_dl_v   [LAT];
      logic [WIDTH-1:0] r_dl_a   [LAT];
      logic [WIDTH-1:0] r_dl_b   [LAT];
      logic             r_dl_cin [LAT];

      // Only the valid bits need reset; a cleared valid bit makes the
      // operand payload in that stage irrelevant.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LAT; i++) begin
            r_dl_v[i] <= 1'b0;
          end
        end else begin
          r_dl_v[0] <= w_accept;
          for (int i = 1; i < LAT; i++) begin
            r_dl_v[i] <= r_dl_v[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        r_dl_a[0]   <= in_a;
        r_dl_b[0]   <= in_b;
        r_dl_cin[0] <= in_cin;
        for (int i = 1; i < LAT; i++) begin
          r_dl_a[i]   <= r_dl_a[i-1];
          r_dl_b[i]   <= r_dl_b[i-1];
          r_dl_cin[i] <= r_dl_cin[i-1];
        end
      end

      assign w_cmp_valid = r_dl_v[LAT-1];
      assign w_cmp_a     = r_dl_a[LAT-1];
      assign w_cmp_b     = r_dl_b[LAT-1];
      assign w_cmp_cin   = r_dl_cin[LAT-1];
    end
  endgenerate

  // Golden result kept at WIDTH+1 bits so the carry-out is compared too.
  assign w_expected = {1'b0, w_cmp_a} + {1'b0, w_cmp_b} + {{WIDTH{1'b0}}, w_cmp_cin};
  assign w_match    = ({dut_cout, dut_sum} == w_expected);

`ifdef CHK_STOP_ON_FAIL_EN
  assign w_fail_stop = w_cmp_valid && !w_match;
`else
  assign w_fail_stop = 1'b0;
`endif

  assign w_stop_run = (r_state == c_RUN) && (stop || w_fail_stop);

  // --------------------------------------------------------------------------
  // Run control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_drain_cnt <= 3'd0;
    end else begin
      case (r_state)
        c_IDLE, c_DONE: begin
          if (w_start_run) begin
            r_state <= c_RUN;
          end
        end
        c_RUN: begin
          if (w_stop_run) begin
            r_state     <= c_DRAIN;
            r_drain_cnt <= c_DRAIN_INIT;
          end
        end
        c_DRAIN: begin
          if (r_drain_cnt == 3'd0) begin
            r_state <= c_DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt - 3'd1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || w_start_run) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_err      <= 1'b0;
      r_ff_a     <= '0;
      r_ff_b     <= '0;
      r_ff_cin   <= 1'b0;
      r_ff_sum   <= '0;
      r_ff_cout  <= 1'b0;
    end else if (w_cmp_valid) begin
      if (w_match) begin
        if (r_pass_cnt != '1) begin
          r_pass_cnt <= r_pass_cnt + c_CNT_ONE;
        end
      end else begin
        if (r_fail_cnt != '1) begin
          r_fail_cnt <= r_fail_cnt + c_CNT_ONE;
        end
        r_err <= 1'b1;
        if (r_fail_cnt == '0) begin
          r_ff_a    <= w_cmp_a;
          r_ff_b    <= w_cmp_b;
          r_ff_cin  <= w_cmp_cin;
          r_ff_sum  <= dut_sum;
          r_ff_cout <= dut_cout;
        end
      end
    end
  end

  assign busy     = (r_state == c_RUN) || (r_state == c_DRAIN);
  assign done     = (r_state == c_DONE);
  assign err      = r_err;
  assign pass_cnt = r_pass_cnt;
  assign fail_cnt = r_fail_cnt;
  assign ff_a     = r_ff_a;
  assign ff_b     = r_ff_b;
  assign ff_cin   = r_ff_cin;
  assign ff_sum   = r_ff_sum;
  assign ff_cout  = r_ff_cout;

endmodule
`default_nettype wire

// File: tb/tb_adder_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_result_checker
// Purpose  : Self-checking bench. Two checkers share one operand stream:
//            u_dut0 (LAT=0, CNT_W=32) sees a combinational adder model and
//            u_dut2 (LAT=2, CNT_W=4) sees the same responses delayed by a
//            two-stage pipeline. Expected results come from a vector-list
//            model evaluated after each run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_result_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic [32:0] cur_resp = '0;
  logic [32:0] resp_d1 = '0;
  logic [32:0] resp_d2 = '0;

  always #5 clk = ~clk;

  // Two-stage pipelined adder response seen by u_dut2.
  always @(posedge clk) begin
    resp_d1 <= cur_resp;
    resp_d2 <= resp_d1;
  end

  logic        busy0, done0, err0, ffcin0, ffcout0;
  logic [31:0] pass0, fail0, ffa0, ffb0, ffsum0;
  logic        busy2, done2, err2, ffcin2, ffcout2;
  logic [3:0]  pass2, fail2;
  logic [31:0] ffa2, ffb2, ffsum2;

  adder_result_checker #(.WIDTH(32), .LAT(0), .CNT_W(32)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .dut_sum(cur_resp[31:0]), .dut_cout(cur_resp[32]),
    .busy(busy0), .done(done0), .err(err0), .pass_cnt(pass0), .fail_cnt(fail0),
    .ff_a(ffa0), .ff_b(ffb0), .ff_cin(ffcin0), .ff_sum(ffsum0), .ff_cout(ffcout0)
  );

  adder_result_checker #(.WIDTH(32), .LAT(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .dut_sum(resp_d2[31:0]), .dut_cout(resp_d2[32]),
    .busy(busy2), .done(done2), .err(err2), .pass_cnt(pass2), .fail_cnt(fail2),
    .ff_a(ffa2), .ff_b(ffb2), .ff_cin(ffcin2), .ff_sum(ffsum2), .ff_cout(ffcout2)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        valid;
    logic        st;
    logic [32:0] resp;
  } vec_t;

  vec_t   stim[$];
  int     checks = 0;
  int     errors = 0;
  int     busy_c0, busy_c2;
  longint e_pass0, e_fail0, e_pass2, e_fail2;
  logic   e_err0, e_err2;
  vec_t   e_ff0, e_ff2;

  function automatic logic [32:0] golden(input logic [31:0] a, input logic [31:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {32'd0, cin};
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic cin,
                              input logic valid, input logic bad);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.valid = valid; v.st = 1'b0;
    v.resp = golden(a, b, cin);
    if (bad) v.resp = v.resp ^ (33'd1 << $urandom_range(0, 32));
    return v;
  endfunction

  // Expected results of the run described by stim for a checker of latency
  // lat and counter width cw: every valid entry up to and including the stop
  // entry is a vector; a response differing from A+B+Cin is a failure.
  task automatic model(input int lat, input int cw, output longint e_pass, output longint e_fail,
                       output logic e_err, output vec_t e_ff);
    int     limit;
    longint max;
    limit = stim.size() - 1;
    e_pass = 0; e_fail = 0; e_err = 1'b0; e_ff = '{default: '0};
    for (int i = 0; i < stim.size(); i++) begin
      if (!stim[i].valid || i > limit) continue;
      if (stim[i].resp == golden(stim[i].a, stim[i].b, stim[i].cin)) begin
        e_pass++;
      end else begin
        if (e_fail == 0) begin
          e_ff = stim[i];
`ifdef CHK_STOP_ON_FAIL_EN
          // Sampling ends once the failing vector reaches the compare stage.
          if (i + lat < limit) limit = i + lat;
`endif
        end
        e_fail++;
        e_err = 1'b1;
      end
    end
    max = (longint'(1) << cw) - 1;
    if (e_pass > max) e_pass = max;
    if (e_fail > max) e_fail = max;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one run: start pulse, the stim entries (stop on the last entry),
  // then wait for both checkers to reach DONE while counting busy cycles.
  task automatic do_run();
    int guard;
    start = 1'b1; in_valid = 1'b0; stop = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < stim.size(); i++) begin
      in_a = stim[i].a; in_b = stim[i].b; in_cin = stim[i].cin;
      in_valid = stim[i].valid; cur_resp = stim[i].resp; start = stim[i].st;
      stop = (i == stim.size() - 1);
      tick();
    end
    stop = 1'b0; start = 1'b0; in_valid = 1'b0;
    busy_c0 = 0; busy_c2 = 0; guard = 0;
    while (!(done0 && done2) && guard < 40) begin
      if (busy0) busy_c0++;
      if (busy2) busy_c2++;
      tick();
      guard++;
    end
    checks++;
    if (!(done0 && done2)) begin
      errors++;
      $display("FAIL run_timeout: done0=%0b done2=%0b, required 1 1", done0, done2);
    end
    model(0, 32, e_pass0, e_fail0, e_err0, e_ff0);
    model(2, 4, e_pass2, e_fail2, e_err2, e_ff2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({busy0, done0, err0, ffcin0, ffcout0} !== 5'b0) begin
      errors++; $display("FAIL reset_flags0: got %b, required 00000", {busy0, done0, err0, ffcin0, ffcout0});
    end
    checks++;
    if ({pass0, fail0, ffa0, ffb0, ffsum0} !== '0) begin
      errors++; $display("FAIL reset_regs0: pass=%0d fail=%0d ff_a=%h ff_b=%h ff_sum=%h, required all 0", pass0, fail0, ffa0, ffb0, ffsum0);
    end
    checks++;
    if ({busy2, done2, err2, ffcin2, ffcout2, pass2, fail2, ffa2, ffb2, ffsum2} !== '0) begin
      errors++; $display("FAIL reset_regs2: busy=%b done=%b err=%b pass=%0d fail=%0d ff_a=%h, required all 0", busy2, done2, err2, pass2, fail2, ffa2);
    end
  endtask

  task automatic test_single_pass();
    stim.delete();
    stim.push_back(mk(32'd5, 32'd7, 1'b1, 1'b1, 1'b0));
    do_run();
    checks++;
    if (pass0 !== 32'(e_pass0) || fail0 !== 32'(e_fail0) || err0 !== e_err0) begin
      errors++; $display("FAIL single_pass0: pass=%0d fail=%0d err=%b, required %0d %0d %b", pass0, fail0, err0, e_pass0, e_fail0, e_err0);
    end
    checks++;
    if (busy_c0 !== 1) begin
      errors++; $display("FAIL single_drain0: busy cycles after stop=%0d, required 1", busy_c0);
    end
    checks++;
    if (busy_c2 !== 3) begin
      errors++; $display("FAIL single_drain2: busy cycles after stop=%0d, required 3", busy_c2);
    end
    checks++;
    if (pass2 !== 4'(e_pass2) || err2 !== e_err2) begin
      errors++; $display("FAIL single_pass2: pass=%0d err=%b, required %0d %b", pass2, err2, e_pass2, e_err2);
    end
  endtask

  task automatic test_fail_capture();
    vec_t v;
    stim.delete();
    v = mk(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b0);
    v.resp = 33'd0;
    stim.push_back(v);
    stim.push_back(mk($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0));
    stim.push_back(mk($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b1));
    do_run();
    checks++;
    if (fail0 !== 32'(e_fail0) || err0 !== e_err0 || pass0 !== 32'(e_pass0)) begin
      errors++; $display("FAIL capture_cnt0: fail=%0d err=%b pass=%0d, required %0d %b %0d", fail0, err0, pass0, e_fail0, e_err0, e_pass0);
    end
    checks++;
    if (ffa0 !== e_ff0.a || ffb0 !== e_ff0.b || ffcin0 !== e_ff0.cin) begin
      errors++; $display("FAIL capture_ops0: a=%h b=%h cin=%b, required %h %h %b", ffa0, ffb0, ffcin0, e_ff0.a, e_ff0.b, e_ff0.cin);
    end
    checks++;
    if ({ffcout0, ffsum0} !== e_ff0.resp) begin
      errors++; $display("FAIL capture_resp0: got %h, required %h", {ffcout0, ffsum0}, e_ff0.resp);
    end
    checks++;
    if (fail2 !== 4'(e_fail2) || ffa2 !== e_ff2.a || {ffcout2, ffsum2} !== e_ff2.resp) begin
      errors++; $display("FAIL capture2: fail=%0d a=%h resp=%h, required %0d %h %h", fail2, ffa2, {ffcout2, ffsum2}, e_fail2, e_ff2.a, e_ff2.resp);
    end
  endtask

  task automatic test_pipe_three();
    stim.delete();
    for (int i = 0; i < 3; i++) stim.push_back(mk($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0));
    stim.push_back(mk(32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
    do_run();
    checks++;
    if (pass2 !== 4'(e_pass2) || fail2 !== 4'(e_fail2)) begin
      errors++; $display("FAIL pipe3_cnt2: pass=%0d fail=%0d, required %0d %0d", pass2, fail2, e_pass2, e_fail2);
    end
    checks++;
    if (busy_c2 !== 3 || done2 !== 1'b1) begin
      errors++; $display("FAIL pipe3_drain2: busy cycles=%0d done=%b, required 3 1", busy_c2, done2);
    end
    checks++;
    if (pass0 !== 32'(e_pass0)) begin
      errors++; $display("FAIL pipe3_cnt0: pass=%0d, required %0d", pass0, e_pass0);
    end
  endtask

  task automatic test_back_to_back_saturation();
    stim.delete();
    for (int i = 0; i < 20; i++) stim.push_back(mk($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0));
    do_run();
    checks++;
    if (pass2 !== 4'(e_pass2) || err2 !== 1'b0) begin
      errors++; $display("FAIL sat_cnt2: pass=%0d err=%b, required %0d 0", pass2, err2, e_pass2);
    end
    checks++;
    if (pass0 !== 32'(e_pass0)) begin
      errors++; $display("FAIL b2b_cnt0: pass=%0d, required %0d", pass0, e_pass0);
    end
    // A stop pulse while in DONE must change nothing.
    stop = 1'b1; tick(); stop = 1'b0; tick();
    checks++;
    if (done0 !== 1'b1 || done2 !== 1'b1 || busy0 !== 1'b0 || pass0 !== 32'(e_pass0)) begin
      errors++; $display("FAIL stop_in_done: done0=%b done2=%b busy0=%b pass0=%0d, required 1 1 0 %0d", done0, done2, busy0, pass0, e_pass0);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      stim.delete();
      for (int i = 0; i < 40; i++) begin
        stim.push_back(mk($urandom, $urandom, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 3) == 0)));
      end
      // Carry wrap-around: all-ones + 0 + 1 = {1, 0}.
      stim[1] = mk(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, 1'b0);
`ifndef CHK_STOP_ON_FAIL_EN
      // A start pulse while running is ignored.
      stim[20].st = 1'b1;
`endif
      do_run();
      checks++;
      if (pass0 !== 32'(e_pass0) || fail0 !== 32'(e_fail0) || err0 !== e_err0) begin
        errors++; $display("FAIL rand%0d_cnt0: pass=%0d fail=%0d err=%b, required %0d %0d %b", r, pass0, fail0, err0, e_pass0, e_fail0, e_err0);
      end
      checks++;
      if (ffa0 !== e_ff0.a || ffb0 !== e_ff0.b || ffcin0 !== e_ff0.cin || {ffcout0, ffsum0} !== e_ff0.resp) begin
        errors++; $display("FAIL rand%0d_ff0: a=%h b=%h cin=%b resp=%h, required %h %h %b %h", r, ffa0, ffb0, ffcin0, {ffcout0, ffsum0}, e_ff0.a, e_ff0.b, e_ff0.cin, e_ff0.resp);
      end
      checks++;
      if (pass2 !== 4'(e_pass2) || fail2 !== 4'(e_fail2) || err2 !== e_err2) begin
        errors++; $display("FAIL rand%0d_cnt2: pass=%0d fail=%0d err=%b, required %0d %0d %b", r, pass2, fail2, err2, e_pass2, e_fail2, e_err2);
      end
      checks++;
      if (ffa2 !== e_ff2.a || ffb2 !== e_ff2.b || ffcin2 !== e_ff2.cin || {ffcout2, ffsum2} !== e_ff2.resp) begin
        errors++; $display("FAIL rand%0d_ff2: a=%h b=%h cin=%b resp=%h, required %h %h %b %h", r, ffa2, ffb2, ffcin2, {ffcout2, ffsum2}, e_ff2.a, e_ff2.b, e_ff2.cin, e_ff2.resp);
      end
    end
  endtask

  task automatic test_reset_midrun();
    vec_t v;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v = mk($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      in_a = v.a; in_b = v.b; in_cin = v.cin; in_valid = 1'b1; cur_resp = v.resp;
      tick();
    end
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy0, done0, busy2, done2} !== 4'b0 || pass0 !== 32'd0 || pass2 !== 4'd0) begin
      errors++; $display("FAIL midrst_state: busy0=%b done0=%b busy2=%b done2=%b pass0=%0d pass2=%0d, required all 0", busy0, done0, busy2, done2, pass0, pass2);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (pass2 !== 4'd0 || fail2 !== 4'd0 || pass0 !== 32'd0 || fail0 !== 32'd0) begin
      errors++; $display("FAIL midrst_late: pass0=%0d fail0=%0d pass2=%0d fail2=%0d, required all 0", pass0, fail0, pass2, fail2);
    end
    stim.delete();
    for (int i = 0; i < 2; i++) stim.push_back(mk($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0));
    do_run();
    checks++;
    if (pass0 !== 32'(e_pass0) || pass2 !== 4'(e_pass2) || fail2 !== 4'(e_fail2)) begin
      errors++; $display("FAIL midrst_rerun: pass0=%0d pass2=%0d fail2=%0d, required %0d %0d %0d", pass0, pass2, fail2, e_pass0, e_pass2, e_fail2);
    end
  endtask

`ifdef CHK_STOP_ON_FAIL_EN
  task automatic test_stop_on_fail();
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(mk($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'(i == 1)));
    for (int i = 0; i < 4; i++) stim.push_back(mk($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0));
    do_run();
    checks++;
    if (pass0 !== 32'(e_pass0) || fail0 !== 32'(e_fail0)) begin
      errors++; $display("FAIL sof_cnt0: pass=%0d fail=%0d, required %0d %0d", pass0, fail0, e_pass0, e_fail0);
    end
    checks++;
    if (pass2 !== 4'(e_pass2) || fail2 !== 4'(e_fail2)) begin
      errors++; $display("FAIL sof_cnt2: pass=%0d fail=%0d, required %0d %0d", pass2, fail2, e_pass2, e_fail2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_pass();
    test_fail_capture();
    test_pipe_three();
    test_back_to_back_saturation();
    test_random();
    test_reset_midrun();
`ifdef CHK_STOP_ON_FAIL_EN
    test_stop_on_fail();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
